// File: rtl/store_buffer_if.sv
// Execute-stage / data-memory bundle for the store buffer.
// The master side is the pipeline and memory observer; the slave side is the buffer.
interface store_buffer_if #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  st_valid;
    logic                  st_ready;
    logic [DM_ADDRESS-1:0] st_addr;
    logic [DATA_W-1:0]     st_data;
    logic [2:0]            st_funct3;
    logic                  ld_req;
    logic [DM_ADDRESS-1:0] ld_addr;
    logic [2:0]            ld_funct3;
    logic                  ld_stall;
    logic                  mem_read;
    logic                  mem_write;
    logic [DM_ADDRESS-1:0] mem_a;
    logic [DATA_W-1:0]     mem_wd;
    logic [2:0]            mem_funct3;
    logic [CW-1:0]         count;
    logic                  st_err;

    modport master (
        output st_valid, st_addr, st_data, st_funct3, ld_req, ld_addr, ld_funct3,
        input  st_ready, ld_stall, mem_read, mem_write, mem_a, mem_wd, mem_funct3,
               count, st_err
    );

    modport slave (
        input  st_valid, st_addr, st_data, st_funct3, ld_req, ld_addr, ld_funct3,
        output st_ready, ld_stall, mem_read, mem_write, mem_a, mem_wd, mem_funct3,
               count, st_err
    );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: FIFO of pending stores that drains into the data memory port
// whenever no load claims it; loads hitting a pending word stall until it drains.
module store_buffer #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int DEPTH      = 4
) (
    input logic           clk,
    input logic           rst_n,
    store_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DM_ADDRESS-1:0] r_addr [DEPTH];
    logic [DATA_W-1:0]     r_data [DEPTH];
    logic [2:0]            r_f3   [DEPTH];
    logic [DEPTH-1:0]      r_vld;
    logic [AW-1:0]         r_head;
    logic [AW-1:0]         r_tail;
    logic [CW-1:0]         r_count;
    logic                  r_err;

    logic w_legal;
    logic w_full;
    logic w_empty;
    logic w_enq;
    logic w_match;
    logic w_hazard;
    logic w_ld_issue;
    logic w_deq;

    always_comb begin
        w_legal = 1'b0;
        case (bus.st_funct3)
            3'b000:  w_legal = 1'b1;
            3'b001:  w_legal = ~bus.st_addr[0];
            3'b010:  w_legal = (bus.st_addr[1:0] == 2'b00);
            default: w_legal = 1'b0;
        endcase
    end

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    // Full is judged on the registered count, so a same-cycle drain never frees a slot.
    assign w_enq   = rst_n & bus.st_valid & ~w_full & w_legal;

    // Only registered entries take part; a store entering this cycle cannot collide.
    always_comb begin
        w_match = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_vld[i] && (r_addr[i][DM_ADDRESS-1:2] == bus.ld_addr[DM_ADDRESS-1:2]))
                w_match = 1'b1;
        end
    end

    assign w_hazard   = rst_n & bus.ld_req & w_match;
    assign w_ld_issue = rst_n & bus.ld_req & ~w_match;
    assign w_deq      = rst_n & ~w_empty & ~w_ld_issue;

    always_comb begin
        bus.mem_read   = 1'b0;
        bus.mem_write  = 1'b0;
        bus.mem_a      = '0;
        bus.mem_wd     = '0;
        bus.mem_funct3 = 3'b000;
        if (w_ld_issue) begin
            bus.mem_read   = 1'b1;
            bus.mem_a      = bus.ld_addr;
            bus.mem_funct3 = bus.ld_funct3;
        end else if (w_deq) begin
            bus.mem_write  = 1'b1;
            bus.mem_a      = r_addr[r_head];
            bus.mem_wd     = r_data[r_head];
            bus.mem_funct3 = r_f3[r_head];
        end
    end

    assign bus.st_ready = w_enq;
    assign bus.ld_stall = w_hazard;
    assign bus.count    = r_count;
    assign bus.st_err   = r_err;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_vld   <= '0;
            r_err   <= 1'b0;
        end else begin
            if (w_enq) begin
                r_vld[r_tail] <= 1'b1;
                r_tail        <= r_tail + 1'b1;
            end
            if (w_deq) begin
                r_vld[r_head] <= 1'b0;
                r_head        <= r_head + 1'b1;
            end
            case ({w_enq, w_deq})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
            if (bus.st_valid && !w_legal)
                r_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_addr[r_tail] <= bus.st_addr;
            r_data[r_tail] <= bus.st_data;
            r_f3[r_tail]   <= bus.st_funct3;
        end
    end
endmodule

// File: tb/tb_store_buffer.sv
// Directed bench for store_buffer: ordering, load arbitration, hazards, errors, reset.
module tb_store_buffer;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    store_buffer_if #(.DM_ADDRESS(9), .DATA_W(32), .DEPTH(4)) bus ();

    store_buffer #(.DM_ADDRESS(9), .DATA_W(32), .DEPTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.st_valid  = 1'b0;
        bus.st_addr   = '0;
        bus.st_data   = '0;
        bus.st_funct3 = 3'b000;
        bus.ld_req    = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_funct3 = 3'b000;
    endtask

    // Loads to a non-matching word keep the port busy so four stores pile up.
    task automatic fill4(input logic [8:0] base, input logic [31:0] dbase);
        bus.ld_req    = 1'b1;
        bus.ld_addr   = 9'h100;
        bus.ld_funct3 = 3'b010;
        for (int i = 0; i < 4; i++) begin
            bus.st_valid  = 1'b1;
            bus.st_addr   = base + 9'(4 * i);
            bus.st_data   = dbase + 32'(i);
            bus.st_funct3 = 3'b010;
            step();
        end
        bus.st_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle_inputs();
        step();
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", bus.count); end
        checks++; if (bus.st_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bus.st_err); end
        checks++; if ({bus.mem_read, bus.mem_write, bus.st_ready, bus.ld_stall} !== 4'b0000) begin
            failures++; $display("FAIL reset_strobes got=%b exp=0000", {bus.mem_read, bus.mem_write, bus.st_ready, bus.ld_stall}); end
        checks++; if ({bus.mem_a, bus.mem_wd, bus.mem_funct3} !== 44'd0) begin
            failures++; $display("FAIL reset_bus got=%0h exp=0", {bus.mem_a, bus.mem_wd, bus.mem_funct3}); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            bus.st_valid  = 1'b1;
            bus.st_addr   = 9'(4 * i);
            bus.st_data   = 32'h1000 + 32'(i);
            bus.st_funct3 = 3'b010;
            @(negedge clk);
            checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL b2b_ready[%0d] got=%0b exp=1", i, bus.st_ready); end
            checks++; if (bus.count !== 3'((i == 0) ? 0 : 1)) begin failures++; $display("FAIL b2b_count[%0d] got=%0d exp=%0d", i, bus.count, (i == 0) ? 0 : 1); end
            if (i == 0) begin
                checks++; if (bus.mem_write !== 1'b0) begin failures++; $display("FAIL b2b_nowrite got=%0b exp=0", bus.mem_write); end
            end else begin
                checks++; if ({bus.mem_write, bus.mem_a, bus.mem_wd} !== {1'b1, 9'(4 * (i - 1)), 32'h1000 + 32'(i - 1)}) begin
                    failures++; $display("FAIL b2b_drain[%0d] got=%0b/%0h/%0h exp=1/%0h/%0h", i, bus.mem_write, bus.mem_a, bus.mem_wd, 4 * (i - 1), 32'h1000 + i - 1); end
            end
            step();
        end
        bus.st_valid = 1'b0;
        @(negedge clk);
        checks++; if ({bus.mem_write, bus.mem_a, bus.mem_wd} !== {1'b1, 9'h00C, 32'h1003}) begin
            failures++; $display("FAIL b2b_last got=%0b/%0h/%0h exp=1/c/1003", bus.mem_write, bus.mem_a, bus.mem_wd); end
        step();
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL b2b_empty got=%0d exp=0", bus.count); end
    endtask

    task automatic test_fill_load();
        bus.ld_req    = 1'b1;
        bus.ld_addr   = 9'h100;
        bus.ld_funct3 = 3'b010;
        for (int i = 0; i < 5; i++) begin
            bus.st_valid  = 1'b1;
            bus.st_addr   = 9'(4 * i);
            bus.st_data   = 32'h2000 + 32'(i);
            bus.st_funct3 = 3'b010;
            @(negedge clk);
            checks++; if (bus.st_ready !== (i < 4)) begin failures++; $display("FAIL fill_ready[%0d] got=%0b exp=%0b", i, bus.st_ready, i < 4); end
            checks++; if (bus.count !== 3'(i)) begin failures++; $display("FAIL fill_count[%0d] got=%0d exp=%0d", i, bus.count, i); end
            checks++; if ({bus.mem_read, bus.mem_write, bus.ld_stall, bus.mem_a, bus.mem_funct3} !== {3'b100, 9'h100, 3'b010}) begin
                failures++; $display("FAIL fill_load[%0d] got=%0b%0b%0b/%0h/%0h exp=100/100/2", i, bus.mem_read, bus.mem_write, bus.ld_stall, bus.mem_a, bus.mem_funct3); end
            step();
        end
        bus.st_valid = 1'b0;
        bus.ld_req   = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({bus.mem_read, bus.mem_write, bus.mem_a, bus.mem_wd} !== {2'b01, 9'(4 * i), 32'h2000 + 32'(i)}) begin
                failures++; $display("FAIL fill_drain[%0d] got=%0b%0b/%0h/%0h exp=01/%0h/%0h", i, bus.mem_read, bus.mem_write, bus.mem_a, bus.mem_wd, 4 * i, 32'h2000 + i); end
            checks++; if (bus.count !== 3'(4 - i)) begin failures++; $display("FAIL fill_dcount[%0d] got=%0d exp=%0d", i, bus.count, 4 - i); end
            step();
        end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL fill_empty got=%0d exp=0", bus.count); end
    endtask

    task automatic test_hazard();
        bus.st_valid  = 1'b1;
        bus.st_addr   = 9'h013;
        bus.st_data   = 32'h0000_00AB;
        bus.st_funct3 = 3'b000;
        @(negedge clk);
        checks++; if ({bus.st_ready, bus.mem_write} !== 2'b10) begin failures++; $display("FAIL haz_sb got=%b exp=10", {bus.st_ready, bus.mem_write}); end
        step();
        bus.st_valid  = 1'b0;
        bus.ld_req    = 1'b1;
        bus.ld_addr   = 9'h010;
        bus.ld_funct3 = 3'b000;
        @(negedge clk);
        checks++; if ({bus.ld_stall, bus.mem_read, bus.mem_write} !== 3'b101) begin
            failures++; $display("FAIL haz_stall got=%b exp=101", {bus.ld_stall, bus.mem_read, bus.mem_write}); end
        checks++; if ({bus.mem_a, bus.mem_wd, bus.mem_funct3} !== {9'h013, 32'h0000_00AB, 3'b000}) begin
            failures++; $display("FAIL haz_drain got=%0h/%0h/%0h exp=13/ab/0", bus.mem_a, bus.mem_wd, bus.mem_funct3); end
        step();
        @(negedge clk);
        checks++; if ({bus.ld_stall, bus.mem_read, bus.mem_write, bus.mem_a} !== {3'b010, 9'h010}) begin
            failures++; $display("FAIL haz_release got=%b/%0h exp=010/10", {bus.ld_stall, bus.mem_read, bus.mem_write}, bus.mem_a); end
        step();
        // A store entering in the same cycle as a load to its word must not stall that load.
        bus.st_valid  = 1'b1;
        bus.st_addr   = 9'h010;
        bus.st_data   = 32'h55;
        bus.st_funct3 = 3'b010;
        bus.ld_funct3 = 3'b010;
        @(negedge clk);
        checks++; if ({bus.st_ready, bus.ld_stall, bus.mem_read} !== 3'b101) begin
            failures++; $display("FAIL haz_sameclk got=%b exp=101", {bus.st_ready, bus.ld_stall, bus.mem_read}); end
        step();
        bus.st_valid = 1'b0;
        bus.ld_req   = 1'b0;
        @(negedge clk);
        checks++; if ({bus.mem_write, bus.mem_a, bus.mem_wd, bus.mem_funct3} !== {1'b1, 9'h010, 32'h55, 3'b010}) begin
            failures++; $display("FAIL haz_late_drain got=%0b/%0h/%0h/%0h exp=1/10/55/2", bus.mem_write, bus.mem_a, bus.mem_wd, bus.mem_funct3); end
        step();
    endtask

    task automatic test_full_drain();
        logic [8:0] exp_a [3];
        fill4(9'h020, 32'h3000);
        exp_a[0] = 9'h028; exp_a[1] = 9'h02C; exp_a[2] = 9'h040;
        bus.ld_req    = 1'b0;
        bus.st_valid  = 1'b1;
        bus.st_addr   = 9'h040;
        bus.st_data   = 32'h77;
        bus.st_funct3 = 3'b010;
        @(negedge clk);
        checks++; if ({bus.st_ready, bus.mem_write, bus.mem_a, bus.count} !== {2'b01, 9'h020, 3'd4}) begin
            failures++; $display("FAIL full_refuse got=%0b%0b/%0h/%0d exp=01/20/4", bus.st_ready, bus.mem_write, bus.mem_a, bus.count); end
        step();
        @(negedge clk);
        checks++; if ({bus.st_ready, bus.mem_write, bus.mem_a, bus.count} !== {2'b11, 9'h024, 3'd3}) begin
            failures++; $display("FAIL full_accept got=%0b%0b/%0h/%0d exp=11/24/3", bus.st_ready, bus.mem_write, bus.mem_a, bus.count); end
        step();
        bus.st_valid = 1'b0;
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            checks++; if ({bus.mem_write, bus.mem_a, bus.count} !== {1'b1, exp_a[j], 3'(3 - j)}) begin
                failures++; $display("FAIL full_order[%0d] got=%0b/%0h/%0d exp=1/%0h/%0d", j, bus.mem_write, bus.mem_a, bus.count, exp_a[j], 3 - j); end
            step();
        end
        checks++; if (bus.count !== 3'd0) begin failures++; $display("FAIL full_empty got=%0d exp=0", bus.count); end
    endtask

    task automatic test_illegal();
        bus.st_valid  = 1'b1;
        bus.st_addr   = 9'h001;
        bus.st_funct3 = 3'b001;
        bus.st_data   = 32'hBEEF;
        @(negedge clk);
        checks++; if ({bus.st_ready, bus.st_err} !== 2'b00) begin failures++; $display("FAIL ill_sh got=%b exp=00", {bus.st_ready, bus.st_err}); end
        step();
        checks++; if ({bus.st_err, bus.count} !== {1'b1, 3'd0}) begin failures++; $display("FAIL ill_sh_err got=%0b/%0d exp=1/0", bus.st_err, bus.count); end
        bus.st_addr   = 9'h006;
        bus.st_funct3 = 3'b010;
        @(negedge clk);
        checks++; if ({bus.st_ready, bus.mem_write} !== 2'b00) begin failures++; $display("FAIL ill_sw got=%b exp=00", {bus.st_ready, bus.mem_write}); end
        step();
        bus.st_addr   = 9'h000;
        bus.st_funct3 = 3'b011;
        @(negedge clk);
        checks++; if (bus.st_ready !== 1'b0) begin failures++; $display("FAIL ill_f3 got=%0b exp=0", bus.st_ready); end
        step();
        checks++; if ({bus.st_err, bus.count} !== {1'b1, 3'd0}) begin failures++; $display("FAIL ill_sticky got=%0b/%0d exp=1/0", bus.st_err, bus.count); end
        bus.st_addr   = 9'h002;
        bus.st_funct3 = 3'b001;
        @(negedge clk);
        checks++; if (bus.st_ready !== 1'b1) begin failures++; $display("FAIL ill_sh_ok got=%0b exp=1", bus.st_ready); end
        step();
        bus.st_valid = 1'b0;
        @(negedge clk);
        checks++; if ({bus.mem_write, bus.mem_a, bus.mem_funct3, bus.st_err} !== {1'b1, 9'h002, 3'b001, 1'b1}) begin
            failures++; $display("FAIL ill_sh_drain got=%0b/%0h/%0h/%0b exp=1/2/1/1", bus.mem_write, bus.mem_a, bus.mem_funct3, bus.st_err); end
        step();
    endtask

    task automatic test_reset_mid();
        fill4(9'h060, 32'h4000);
        bus.ld_req = 1'b0;
        @(negedge clk);
        checks++; if ({bus.mem_write, bus.mem_a, bus.count} !== {1'b1, 9'h060, 3'd4}) begin
            failures++; $display("FAIL rmid_pre got=%0b/%0h/%0d exp=1/60/4", bus.mem_write, bus.mem_a, bus.count); end
        step();
        rst_n = 1'b0;
        #1;
        checks++; if ({bus.mem_write, bus.mem_read, bus.count, bus.st_err} !== {2'b00, 3'd0, 1'b0}) begin
            failures++; $display("FAIL rmid_async got=%0b%0b/%0d/%0b exp=00/0/0", bus.mem_write, bus.mem_read, bus.count, bus.st_err); end
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++; if ({bus.mem_write, bus.count} !== {1'b0, 3'd0}) begin
                failures++; $display("FAIL rmid_after[%0d] got=%0b/%0d exp=0/0", i, bus.mem_write, bus.count); end
            step();
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        idle_inputs();
        test_reset();
        test_back_to_back();
        test_fill_load();
        test_hazard();
        test_full_drain();
        test_illegal();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
